// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Contents:
//   state_e          - data-memory handshake FSM states
//   REG_ZERO         - architectural $zero register index
//   DEF_MEM_TIMEOUT  - default maximum consecutive MEM_WAIT cycles
//   DEF_CNT_W        - default width of the stall performance counter
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         DEF_MEM_TIMEOUT = 16;
    localparam int         DEF_CNT_W       = 16;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   id_rs, id_rt   in  - source register fields of the instruction in ID
//   id_uses_rt     in  - ID instruction reads rt as a source
//   ex_memread     in  - instruction in EX is a load
//   ex_rt          in  - load destination register in EX
//   load_use       out - ID instruction needs the value the EX load produces
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    output logic       load_use
);

    // A load into $zero never creates a dependence; rt only matters when read.
    assign load_use = ex_memread && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline control for the 5-stage MIPS core.
// Produces pipeline-register enables/flushes from load-use hazards, taken
// branches in EX and the data-memory wait-state handshake; tracks a sticky
// memory timeout flag and a saturating stall-cycle counter.
// Ports:
//   clk, reset_n               in  - clock, async active-low reset
//   id_rs, id_rt, id_uses_rt   in  - ID source operands
//   ex_memread, ex_rt          in  - EX load info
//   ex_branch_taken            in  - branch resolved taken in EX
//   mem_access, dmem_ready     in  - MEM stage access and memory completion
//   perf_clr                   in  - synchronous clear of perf counter
//   dmem_req                   out - memory access request
//   pc_write, ifid_write       out - PC / IF-ID enables
//   ifid_flush, idex_flush     out - IF-ID / ID-EX flushes
//   exmem_write                out - EX-MEM enable
//   memwb_flush                out - MEM-WB bubble insert
//   mem_timeout_err            out - sticky timeout flag
//   perf_stall_cycles          out - saturating stall-cycle count
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic             perf_clr,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_flush,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] perf_stall_cycles
);

    // wait_cnt never exceeds MEM_TIMEOUT-1 because the timeout exits MEM_WAIT.
    localparam int              WC_W      = $clog2(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_e          state_r;
    logic [WC_W-1:0] wait_cnt_r;
    logic            load_use_s;
    logic            timeout_s;
    logic            mem_stall_s;

    hazard_detect u_hazard_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .load_use   (load_use_s)
    );

    assign dmem_req = mem_access;

    // Timeout detection and the memory stall it overrides.
    always_comb begin
        timeout_s   = (state_r == MEM_WAIT) && !dmem_ready && (wait_cnt_r == WAIT_LAST);
        mem_stall_s = mem_access && !dmem_ready && !timeout_s;
    end

    // Priority mux: memory stall > taken branch > load-use > free-run.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        memwb_flush = timeout_s;
        if (mem_stall_s) begin
            // EX is frozen, so a branch or load-use there re-presents later.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            // Squashing ID also discards any load-use dependence it had.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use_s) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else begin
            pc_write = 1'b1;
        end
    end

    // Memory wait-state FSM, its cycle counter and the sticky timeout flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= RUN;
            wait_cnt_r      <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    wait_cnt_r <= '0;
                    if (mem_access && !dmem_ready) begin
                        state_r <= MEM_WAIT;
                    end else begin
                        state_r <= RUN;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready || timeout_s) begin
                        state_r    <= RUN;
                        wait_cnt_r <= '0;
                    end else begin
                        state_r    <= MEM_WAIT;
                        wait_cnt_r <= wait_cnt_r + WC_W'(1);
                    end
                end
                default: begin
                    state_r    <= RUN;
                    wait_cnt_r <= '0;
                end
            endcase
            if (timeout_s) begin
                mem_timeout_err <= 1'b1;
            end else begin
                mem_timeout_err <= mem_timeout_err;
            end
        end
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cycles <= '0;
        end else if (perf_clr) begin
            perf_stall_cycles <= '0;
        end else if (!pc_write && (perf_stall_cycles != {CNT_W{1'b1}})) begin
            perf_stall_cycles <= perf_stall_cycles + CNT_W'(1);
        end else begin
            perf_stall_cycles <= perf_stall_cycles;
        end
    end

endmodule
